// File: rtl/hamming_secded_stream_if.sv
// Valid/ready stream bundle for the SECDED codec: input word plus mode,
// output codeword, extracted data, syndrome and error flags.
interface hamming_secded_stream_if #(
    parameter int DATA_W = 4
);
    function automatic int calc_par_w(input int dw);
        int p;
        p = 1;
        while ((1 << p) < (dw + p + 1)) begin
            p = p + 1;
        end
        return p;
    endfunction

    localparam int PAR_W  = calc_par_w(DATA_W);
    localparam int CODE_W = DATA_W + PAR_W + 1;

    logic              in_valid;
    logic              in_ready;
    logic              in_mode;
    logic [CODE_W-1:0] in_word;
    logic              out_valid;
    logic              out_ready;
    logic [CODE_W-1:0] out_code;
    logic [DATA_W-1:0] out_data;
    logic [PAR_W-1:0]  out_syndrome;
    logic              out_err_single;
    logic              out_err_double;

    modport master (
        output in_valid, in_mode, in_word, out_ready,
        input  in_ready, out_valid, out_code, out_data, out_syndrome,
               out_err_single, out_err_double
    );

    modport slave (
        input  in_valid, in_mode, in_word, out_ready,
        output in_ready, out_valid, out_code, out_data, out_syndrome,
               out_err_single, out_err_double
    );
endinterface

// File: rtl/hamming_secded_stream.sv
// Registered extended-Hamming SECDED encoder/decoder on a valid/ready stream,
// with saturating corrected/uncorrectable word counters for status display.
module hamming_secded_stream #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hamming_secded_stream_if.slave io,
    input  logic                 clr_cnt,
    output logic [CNT_W-1:0]     corr_cnt,
    output logic [CNT_W-1:0]     uncorr_cnt
);
    function automatic int calc_par_w(input int dw);
        int p;
        p = 1;
        while ((1 << p) < (dw + p + 1)) begin
            p = p + 1;
        end
        return p;
    endfunction

    localparam int PAR_W  = calc_par_w(DATA_W);
    localparam int CODE_W = DATA_W + PAR_W + 1;

    // Data bits occupy the non-power-of-two positions, LSB first at position 3.
    function automatic logic [CODE_W-1:0] place_data(input logic [DATA_W-1:0] d);
        logic [CODE_W-1:0] c;
        int j;
        c = '0;
        j = 0;
        for (int i = 1; i < CODE_W; i++) begin
            if ((i & (i - 1)) != 0) begin
                c[i] = d[j];
                j = j + 1;
            end else begin
                c[i] = 1'b0;
            end
        end
        return c;
    endfunction

    function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] c);
        logic [DATA_W-1:0] d;
        int j;
        d = '0;
        j = 0;
        for (int i = 1; i < CODE_W; i++) begin
            if ((i & (i - 1)) != 0) begin
                d[j] = c[i];
                j = j + 1;
            end else begin
                d = d;
            end
        end
        return d;
    endfunction

    function automatic logic [PAR_W-1:0] calc_syndrome(input logic [CODE_W-1:0] c);
        logic [PAR_W-1:0] s;
        s = '0;
        for (int i = 1; i < CODE_W; i++) begin
            if (c[i]) begin
                s = s ^ PAR_W'(i);
            end else begin
                s = s;
            end
        end
        return s;
    endfunction

    // Parity bits cancel the data syndrome, then bit 0 makes the whole word even.
    function automatic logic [CODE_W-1:0] encode_word(input logic [DATA_W-1:0] d);
        logic [CODE_W-1:0] c;
        logic [PAR_W-1:0]  s;
        c = place_data(d);
        s = calc_syndrome(c);
        for (int k = 0; k < PAR_W; k++) begin
            c[1 << k] = s[k];
        end
        c[0] = ^c[CODE_W-1:1];
        return c;
    endfunction

    logic              accept_s;
    logic [PAR_W-1:0]  rx_syn_s;
    logic              rx_par_s;
    logic [CODE_W-1:0] code_s;
    logic [DATA_W-1:0] data_s;
    logic [PAR_W-1:0]  syn_s;
    logic              single_s;
    logic              double_s;

    logic              out_valid_r;
    logic [CODE_W-1:0] out_code_r;
    logic [DATA_W-1:0] out_data_r;
    logic [PAR_W-1:0]  out_syn_r;
    logic              out_single_r;
    logic              out_double_r;
    logic [CNT_W-1:0]  corr_cnt_r;
    logic [CNT_W-1:0]  uncorr_cnt_r;

    assign io.in_ready = ~out_valid_r | io.out_ready;
    assign accept_s    = io.in_valid & io.in_ready;

    // Combinational encode or decode/classify of the word on the input port.
    always_comb begin
        rx_syn_s = calc_syndrome(io.in_word);
        rx_par_s = ^io.in_word;
        code_s   = io.in_word;
        data_s   = extract_data(io.in_word);
        syn_s    = '0;
        single_s = 1'b0;
        double_s = 1'b0;
        if (!io.in_mode) begin
            code_s = encode_word(io.in_word[DATA_W-1:0]);
            data_s = io.in_word[DATA_W-1:0];
        end else begin
            syn_s = rx_syn_s;
            if (rx_syn_s == '0) begin
                if (rx_par_s) begin
                    code_s   = io.in_word ^ CODE_W'(1);
                    single_s = 1'b1;
                end else begin
                    code_s = io.in_word;
                end
            end else if (rx_par_s) begin
                if (int'(rx_syn_s) <= (CODE_W - 1)) begin
                    code_s   = io.in_word ^ (CODE_W'(1) << rx_syn_s);
                    single_s = 1'b1;
                end else begin
                    double_s = 1'b1;
                end
            end else begin
                double_s = 1'b1;
            end
            data_s = extract_data(code_s);
        end
    end

    // Single output stage: load on accept, otherwise drop valid once drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r  <= 1'b0;
            out_code_r   <= '0;
            out_data_r   <= '0;
            out_syn_r    <= '0;
            out_single_r <= 1'b0;
            out_double_r <= 1'b0;
        end else if (accept_s) begin
            out_valid_r  <= 1'b1;
            out_code_r   <= code_s;
            out_data_r   <= data_s;
            out_syn_r    <= syn_s;
            out_single_r <= single_s;
            out_double_r <= double_s;
        end else if (io.out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    // Error counters count at input accept; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_cnt_r   <= '0;
            uncorr_cnt_r <= '0;
        end else if (clr_cnt) begin
            corr_cnt_r   <= '0;
            uncorr_cnt_r <= '0;
        end else begin
            if (accept_s && io.in_mode && single_s && (corr_cnt_r != '1)) begin
                corr_cnt_r <= corr_cnt_r + CNT_W'(1);
            end
            if (accept_s && io.in_mode && double_s && (uncorr_cnt_r != '1)) begin
                uncorr_cnt_r <= uncorr_cnt_r + CNT_W'(1);
            end
        end
    end

    assign io.out_valid      = out_valid_r;
    assign io.out_code       = out_code_r;
    assign io.out_data       = out_data_r;
    assign io.out_syndrome   = out_syn_r;
    assign io.out_err_single = out_single_r;
    assign io.out_err_double = out_double_r;
    assign corr_cnt          = corr_cnt_r;
    assign uncorr_cnt        = uncorr_cnt_r;
endmodule

// File: tb/tb_hamming_secded_stream.sv
// Directed bench for hamming_secded_stream with DATA_W=4 (8-bit codewords)
// and 2-bit counters so saturation is reachable in a few words.
module tb_hamming_secded_stream;
    logic       clk;
    logic       rst_n;
    logic       clr_cnt;
    logic [1:0] corr_cnt;
    logic [1:0] uncorr_cnt;
    int         errors;
    int         checks;

    hamming_secded_stream_if #(.DATA_W(4)) bus ();

    hamming_secded_stream #(.DATA_W(4), .CNT_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .io         (bus.slave),
        .clr_cnt    (clr_cnt),
        .corr_cnt   (corr_cnt),
        .uncorr_cnt (uncorr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one word and let it be accepted on the next rising edge.
    task automatic send(input logic mode, input logic [7:0] word);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_mode  = mode;
        bus.in_word  = word;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        rst_n         = 1'b0;
        clr_cnt       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_mode   = 1'b0;
        bus.in_word   = 8'h00;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_code", 32'(bus.out_code), 32'h0);
        chk("rst_corr", 32'(corr_cnt), 32'h0);
        chk("rst_uncorr", 32'(uncorr_cnt), 32'h0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        send(1'b0, 8'h0A);
        chk("enc_a_valid", 32'(bus.out_valid), 32'h1);
        chk("enc_a_code", 32'(bus.out_code), 32'hA5);
        chk("enc_a_data", 32'(bus.out_data), 32'hA);
        chk("enc_a_syn", 32'(bus.out_syndrome), 32'h0);
        chk("enc_a_flags", 32'({bus.out_err_single, bus.out_err_double}), 32'h0);
        send(1'b0, 8'h0F);
        chk("enc_f_code", 32'(bus.out_code), 32'hFF);
        send(1'b0, 8'hF0);
        chk("enc_0_code", 32'(bus.out_code), 32'h00);
        chk("enc_0_data", 32'(bus.out_data), 32'h0);
        chk("enc_no_cnt", 32'(corr_cnt), 32'h0);

        send(1'b1, 8'h85);
        chk("dec85_code", 32'(bus.out_code), 32'hA5);
        chk("dec85_data", 32'(bus.out_data), 32'hA);
        chk("dec85_syn", 32'(bus.out_syndrome), 32'h5);
        chk("dec85_single", 32'(bus.out_err_single), 32'h1);
        chk("dec85_double", 32'(bus.out_err_double), 32'h0);
        chk("dec85_corr", 32'(corr_cnt), 32'h1);
        send(1'b1, 8'hA4);
        chk("decA4_code", 32'(bus.out_code), 32'hA5);
        chk("decA4_syn", 32'(bus.out_syndrome), 32'h0);
        chk("decA4_single", 32'(bus.out_err_single), 32'h1);
        chk("decA4_corr", 32'(corr_cnt), 32'h2);
        send(1'b1, 8'hA3);
        chk("decA3_double", 32'(bus.out_err_double), 32'h1);
        chk("decA3_single", 32'(bus.out_err_single), 32'h0);
        chk("decA3_syn", 32'(bus.out_syndrome), 32'h3);
        chk("decA3_code", 32'(bus.out_code), 32'hA3);
        chk("decA3_data", 32'(bus.out_data), 32'hA);
        chk("decA3_uncorr", 32'(uncorr_cnt), 32'h1);
        chk("decA3_corr", 32'(corr_cnt), 32'h2);
        @(posedge clk);
        #1;
        chk("drain_valid", 32'(bus.out_valid), 32'h0);

        // Stream of four encodes with a three-cycle downstream stall mid-way.
        send(1'b0, 8'h01);
        chk("s1_code", 32'(bus.out_code), 32'h0F);
        send(1'b0, 8'h02);
        chk("s2_code", 32'(bus.out_code), 32'h33);
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_mode   = 1'b0;
        bus.in_word   = 8'h03;
        #1;
        chk("stall_in_ready", 32'(bus.in_ready), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("stall_code", 32'(bus.out_code), 32'h33);
            chk("stall_data", 32'(bus.out_data), 32'h2);
            chk("stall_valid", 32'(bus.out_valid), 32'h1);
            chk("stall_ready", 32'(bus.in_ready), 32'h0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        chk("resume_ready", 32'(bus.in_ready), 32'h1);
        @(posedge clk);
        #1;
        chk("s3_code", 32'(bus.out_code), 32'h3C);
        @(negedge clk);
        bus.in_word = 8'h04;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("s4_code", 32'(bus.out_code), 32'h55);
        chk("s4_valid", 32'(bus.out_valid), 32'h1);
        @(posedge clk);
        #1;
        chk("s_end_valid", 32'(bus.out_valid), 32'h0);

        // Saturation of the 2-bit corrected counter, then clear beating increment.
        @(negedge clk);
        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        chk("clr_corr", 32'(corr_cnt), 32'h0);
        chk("clr_uncorr", 32'(uncorr_cnt), 32'h0);
        for (int i = 0; i < 5; i++) begin
            send(1'b1, 8'h85);
            chk("sat_corr", 32'(corr_cnt), (i + 1 > 3) ? 32'h3 : 32'(i + 1));
        end
        @(negedge clk);
        clr_cnt      = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_mode  = 1'b1;
        bus.in_word  = 8'h85;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        clr_cnt      = 1'b0;
        chk("clr_prio_corr", 32'(corr_cnt), 32'h0);
        chk("clr_prio_single", 32'(bus.out_err_single), 32'h1);

        // Reset while a word is held under backpressure.
        @(posedge clk);
        #1;
        chk("pre_rst_valid", 32'(bus.out_valid), 32'h0);
        @(negedge clk);
        bus.out_ready = 1'b0;
        send(1'b1, 8'hA3);
        chk("held_valid", 32'(bus.out_valid), 32'h1);
        chk("held_uncorr", 32'(uncorr_cnt), 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.out_valid), 32'h0);
        chk("arst_code", 32'(bus.out_code), 32'h0);
        chk("arst_data", 32'(bus.out_data), 32'h0);
        chk("arst_syn", 32'(bus.out_syndrome), 32'h0);
        chk("arst_double", 32'(bus.out_err_double), 32'h0);
        chk("arst_uncorr", 32'(uncorr_cnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("post_rst_valid", 32'(bus.out_valid), 32'h0);
        end
        bus.out_ready = 1'b1;
        send(1'b0, 8'h0A);
        chk("post_rst_code", 32'(bus.out_code), 32'hA5);
        chk("post_rst_valid1", 32'(bus.out_valid), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
